// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states
// and the bit positions of the instruction fields.
package seq_pkg;

  // Opcodes carried in instr[15:12]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_ADDC  = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_SUBB  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_MOVIL = 4'hB;
  localparam logic [3:0] OP_MOVIH = 4'hC;
  localparam logic [3:0] OP_LOAD  = 4'hD;
  localparam logic [3:0] OP_STORE = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Instruction field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes ADD..LOAD write a destination register; NOP/STORE/HALT do not
  function automatic logic writes_reg(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LOAD);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Memory handshakes and register-file control bundle of the sequencer.
// master = sequencer side, slave = memories / register file side.
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_ack_pi;
  logic [15:0]         imem_data_pi;
  logic                dmem_ack_pi;
  logic                imem_req_po;
  logic [PC_WIDTH-1:0] imem_addr_po;
  logic                dmem_req_po;
  logic                dmem_we_po;
  logic [2:0]          source_reg1_po;
  logic [2:0]          source_reg2_po;
  logic [2:0]          destination_reg_po;
  logic                wr_destination_reg_po;
  logic                movi_lower_po;
  logic                movi_higher_po;
  logic [7:0]          immediate_po;
  logic [3:0]          alu_func_po;
  logic                load_sel_po;
  logic                clk_en_po;
  logic                halted_po;

  modport master (
    input  imem_ack_pi, imem_data_pi, dmem_ack_pi,
    output imem_req_po, imem_addr_po, dmem_req_po, dmem_we_po,
           source_reg1_po, source_reg2_po, destination_reg_po,
           wr_destination_reg_po, movi_lower_po, movi_higher_po,
           immediate_po, alu_func_po, load_sel_po, clk_en_po, halted_po
  );

  modport slave (
    output imem_ack_pi, imem_data_pi, dmem_ack_pi,
    input  imem_req_po, imem_addr_po, dmem_req_po, dmem_we_po,
           source_reg1_po, source_reg2_po, destination_reg_po,
           wr_destination_reg_po, movi_lower_po, movi_higher_po,
           immediate_po, alu_func_po, load_sel_po, clk_en_po, halted_po
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into register-file
// and ALU controls. Driven from the IR, so outputs only move when a new
// instruction is latched.
module instr_decode
  import seq_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  src1,
  output logic [2:0]  src2,
  output logic [2:0]  dest,
  output logic        wr,
  output logic        movi_lower,
  output logic        movi_higher,
  output logic        load_sel,
  output logic [7:0]  imm,
  output logic [3:0]  alu_func
);

  // Field extraction and opcode classification
  always_comb begin
    src1        = ir[RS1_MSB:RS1_LSB];
    src2        = ir[RS2_MSB:RS2_LSB];
    dest        = ir[RD_MSB:RD_LSB];
    imm         = ir[IMM_MSB:IMM_LSB];
    alu_func    = ir[OP_MSB:OP_LSB];
    wr          = writes_reg(ir[OP_MSB:OP_LSB]);
    movi_lower  = (ir[OP_MSB:OP_LSB] == OP_MOVIL);
    movi_higher = (ir[OP_MSB:OP_LSB] == OP_MOVIH);
    load_sel    = (ir[OP_MSB:OP_LSB] == OP_LOAD);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/control sequencer feeding the 8x16 register file.
// Holds PC and IR, runs FETCH-DECODE-EXEC-[MEM]-WB and pulses clk_en_po
// once per committed instruction.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk_pi,
  input  logic               reset_pi,
  instr_sequencer_if.master  seq_bus
);

  state_t              state_reg;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [15:0]         ir_reg;
  logic                imem_req_reg;
  logic                dmem_req_reg;
  logic                dmem_we_reg;
  logic                clk_en_reg;
  logic                halted_reg;
  logic [3:0]          op;

  logic [2:0] dec_src1;
  logic [2:0] dec_src2;
  logic [2:0] dec_dest;
  logic       dec_wr;
  logic       dec_movi_lower;
  logic       dec_movi_higher;
  logic       dec_load_sel;
  logic [7:0] dec_imm;
  logic [3:0] dec_alu_func;

  assign op = ir_reg[OP_MSB:OP_LSB];

  instr_decode u_decode (
    .ir          (ir_reg),
    .src1        (dec_src1),
    .src2        (dec_src2),
    .dest        (dec_dest),
    .wr          (dec_wr),
    .movi_lower  (dec_movi_lower),
    .movi_higher (dec_movi_higher),
    .load_sel    (dec_load_sel),
    .imm         (dec_imm),
    .alu_func    (dec_alu_func)
  );

  // Sequencer FSM; every handshake output is a register set on the
  // transition into the state that owns it. Reset beats any ack.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      imem_req_reg <= 1'b0;
      dmem_req_reg <= 1'b0;
      dmem_we_reg  <= 1'b0;
      clk_en_reg   <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      clk_en_reg <= 1'b0;
      case (state_reg)
        ST_FETCH: begin
          // An ack only counts while our request is visible
          if (imem_req_reg && seq_bus.imem_ack_pi) begin
            ir_reg       <= seq_bus.imem_data_pi;
            imem_req_reg <= 1'b0;
            state_reg    <= ST_DECODE;
          end else begin
            imem_req_reg <= 1'b1;
          end
        end
        ST_DECODE: state_reg <= ST_EXEC;
        ST_EXEC: begin
          if (op == OP_LOAD || op == OP_STORE) begin
            dmem_req_reg <= 1'b1;
            dmem_we_reg  <= (op == OP_STORE);
            state_reg    <= ST_MEM;
          end else if (op == OP_HALT) begin
            halted_reg <= 1'b1;
            state_reg  <= ST_HALT;
          end else begin
            clk_en_reg <= 1'b1;
            state_reg  <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_req_reg && seq_bus.dmem_ack_pi) begin
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            clk_en_reg   <= 1'b1;
            state_reg    <= ST_WB;
          end
        end
        ST_WB: begin
          // PC wraps naturally at its width; request the next fetch now
          // so a zero-wait memory gives a 4-cycle instruction.
          pc_reg       <= pc_reg + 1'b1;
          imem_req_reg <= 1'b1;
          state_reg    <= ST_FETCH;
        end
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

  assign seq_bus.imem_req_po           = imem_req_reg;
  assign seq_bus.imem_addr_po          = pc_reg;
  assign seq_bus.dmem_req_po           = dmem_req_reg;
  assign seq_bus.dmem_we_po            = dmem_we_reg;
  assign seq_bus.clk_en_po             = clk_en_reg;
  assign seq_bus.halted_po             = halted_reg;
  assign seq_bus.source_reg1_po        = dec_src1;
  assign seq_bus.source_reg2_po        = dec_src2;
  assign seq_bus.destination_reg_po    = dec_dest;
  assign seq_bus.wr_destination_reg_po = dec_wr;
  assign seq_bus.movi_lower_po         = dec_movi_lower;
  assign seq_bus.movi_higher_po        = dec_movi_higher;
  assign seq_bus.load_sel_po           = dec_load_sel;
  assign seq_bus.immediate_po          = dec_imm;
  assign seq_bus.alu_func_po           = dec_alu_func;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/control sequencer directly upstream of the 8x16 register file.
- Holds the 8-bit PC and fetches 16-bit instructions over a req/ack handshake.
- Decodes each instruction into register-file controls (source/destination indices, write enable, MOVI lower/higher, immediate) plus an ALU function code.
- Issues a one-cycle clock-enable pulse that commits the register file and carry/borrow flags.

Parameters:
PC_WIDTH, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk_pi  in  1  system clock, all state on rising edge
reset_pi  in  1  synchronous, active-high reset
imem_ack_pi  in  1  instruction memory: imem_data_pi valid this cycle
imem_data_pi  in  16  fetched instruction word
dmem_ack_pi  in  1  data memory: access complete; load data valid this cycle
imem_req_po  out  1  instruction fetch request, held until ack
imem_addr_po  out  PC_WIDTH  fetch address (= PC)
dmem_req_po  out  1  data access request, held until ack
dmem_we_po  out  1  1 = STORE, 0 = LOAD (valid while dmem_req_po)
source_reg1_po  out  3  register-file read index 1 (instr[8:6])
source_reg2_po  out  3  register-file read index 2 (instr[5:3])
destination_reg_po  out  3  write/STORE-source index (instr[11:9])
wr_destination_reg_po  out  1  register write enable for current instruction
movi_lower_po  out  1  MOVIL decode
movi_higher_po  out  1  MOVIH decode
immediate_po  out  8  instr[7:0]
alu_func_po  out  4  opcode passed to the ALU
load_sel_po  out  1  1 = register write data comes from data memory
clk_en_po  out  1  one-cycle commit pulse to the register file
halted_po  out  1  sequencer stopped on HALT

Behaviour:
- Interface: single clock clk_pi; reset_pi is synchronous, active-high, sampled on the rising edge of clk_pi.
- Encoding: opcode instr[15:12].
  - 0 NOP, 1 ADD, 2 ADDC, 3 SUB, 4 SUBB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 SHL, A SHR
  - B MOVIL, C MOVIH, D LOAD, E STORE, F HALT
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req_po=1, imem_addr_po=PC.
  - On imem_ack_pi, latch imem_data_pi into IR and go to DECODE. Without ack, stay in FETCH; there is no timeout.
- DECODE (1 cycle): all decode outputs become valid from IR; go to EXEC.
- EXEC (1 cycle):
  - LOAD/STORE go to MEM.
  - HALT goes to HALT.
  - Everything else goes to WB.
- MEM:
  - dmem_req_po=1; dmem_we_po=1 for STORE, 0 for LOAD.
  - Hold until dmem_ack_pi, then go to WB.
- WB (1 cycle):
  - clk_en_po=1, PC<=PC+1 (wraps at 2^PC_WIDTH-1 to 0); go to FETCH.
- HALT: halted_po=1 and stays in HALT until reset. clk_en_po is never pulsed for HALT.
- wr_destination_reg_po = 1 for opcodes 1-D. It is 0 for NOP, STORE and HALT, so NOP/STORE commit flags only.
- MOVI decode: movi_lower_po = (op==B); movi_higher_po = (op==C).
- load_sel_po = (op==D).
- Decode outputs are stable from DECODE through WB and change only when a new IR is latched. Per instruction: FETCH ≥1 cycle, then DECODE 1, EXEC 1, [MEM ≥1], WB 1.
- Total latency: 4 cycles with zero-wait ack, 5 for LOAD/STORE.
- Simultaneous reset and ack: reset wins; the ack is ignored.
- Reset (any state, including mid-MEM):
  - State=FETCH, PC=RESET_PC, IR=0 (NOP).
  - All outputs 0 except imem_addr_po=RESET_PC.
  - imem_req_po asserts in the first cycle after reset deasserts.
- An ack arriving while its request is low is ignored.

Decomposition:
- Package seq_pkg:
  - 4-bit opcode constants OP_NOP..OP_HALT.
  - State encoding (3-bit localparams FETCH..HALT).
  - Instruction field bit positions.
- One combinational sub-module instr_decode maps IR to wr/movi/load_sel/alu_func/register indices.
- FSM and PC stay in instr_sequencer.

Test Plan:
- Reset then imem ack with 16'h1298 (ADD rd=1, rs1=2, rs2=3) → in DECODE: dest=1, src1=2, src2=3, wr=1, alu_func=1; clk_en_po pulses exactly once, 3 cycles after ack; PC 0→1.
- 16'hB5A7 (MOVIL rd=2, imm=A7) → movi_lower_po=1, movi_higher_po=0, immediate_po=8'hA7, wr=1 at the WB pulse. 16'hC5A7 → movi_higher_po=1 instead.
- LOAD 16'hD240 with dmem_ack delayed 3 cycles → dmem_req_po high 3 cycles with dmem_we_po=0, load_sel_po=1; clk_en_po pulses the cycle after ack.
- STORE 16'hE200 → dmem_we_po=1, wr=0, clk_en_po pulses once; HALT 16'hF000 → halted_po=1, no further imem_req_po, no clk_en_po for ≥20 cycles.
- PC_WIDTH=8 with PC=8'hFF, then execute a NOP → imem_addr_po=8'h00 on the next fetch.
- Assert reset_pi during MEM with dmem_ack_pi high in the same cycle → next cycle all outputs 0, PC=0, no clk_en_po pulse; fetch restarts at address 0.
